vehicle_demand_detector: RTL and testbench

//  Produces the country-road car-present request `x` consumed by the traffic light controller.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/tlc_sync2.sv | 29 ++
 rtl/vehicle_demand_detector.sv | 168 ++++++++++++++++
 tb/tb_vehicle_demand_detector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic-light types: light codes seen by the controller and detector state encoding.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package traffic_pkg;

    // Country/highway light code as driven by the light controller. Value 3 is illegal
    // and is deliberately kept representable so consumers can treat it as "not GREEN".
    typedef logic [1:0] light_t;

    localparam light_t RED    = 2'd0;
    localparam light_t YELLOW = 2'd1;
    localparam light_t GREEN  = 2'd2;

    // Loop-detector state machine encoding.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUALIFY  = 3'd1,
        OCCUPIED = 3'd2,
        RELEASE  = 3'd3,
        FAULT    = 3'd4
    } det_state_t;

    // States in which a car is considered physically present (or assumed present on a fault).
    function automatic logic state_has_vehicle(input det_state_t s);
        return (s == OCCUPIED) || (s == RELEASE) || (s == FAULT);
    endfunction

endpackage

// File: rtl/tlc_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, async active-low clear.
// Latency: 2 clk edges from input capture to output.
// Backpressure: none (free-running level path).
module tlc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability-settling pair; nothing else may sample i_d.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/vehicle_demand_detector.sv
// Country-road demand for the light controller: sync + debounce the loop, latch demand until GREEN, fail safe on a stuck loop.
// Latency: loop edge to x change is DEBOUNCE_CYCLES+2 clk edges; cntry==GREEN clears the latch on the next edge.
// Backpressure: none; level-in/level-out. Optional veh_count port under macro VEH_COUNT_EN.
module vehicle_demand_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             loop_raw,
    input  light_t           cntry,
`ifdef VEH_COUNT_EN
    output logic [CNT_W-1:0] veh_count,
`endif
    output logic             x,
    output logic             stuck_fault
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int OCNT_W = $clog2(STUCK_CYCLES);

    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(STUCK_CYCLES - 1);

    // Reject configurations the counters cannot represent correctly.
    generate
        if (DEBOUNCE_CYCLES < 2 || STUCK_CYCLES <= DEBOUNCE_CYCLES || CNT_W < 1) begin : g_bad_params
            $error("vehicle_demand_detector: need DEBOUNCE_CYCLES>=2, STUCK_CYCLES>DEBOUNCE_CYCLES, CNT_W>=1");
        end
    endgenerate

    // clear is expected to be released synchronously upstream; assertion acts immediately.
    logic w_loop_s;

    tlc_sync2 #(
        .WIDTH (1)
    ) u_loop_sync (
        .i_clk   (clk),
        .i_rst_n (clear),
        .i_d     (loop_raw),
        .o_q     (w_loop_s)
    );

    det_state_t        r_state;
    det_state_t        w_state_nxt;
    logic [DCNT_W-1:0] r_dcnt;
    logic [DCNT_W-1:0] w_dcnt_nxt;
    logic [OCNT_W-1:0] r_ocnt;
    logic [OCNT_W-1:0] w_ocnt_nxt;
    logic              w_accept;
    logic              r_demand_latch;

    // State and debounce/occupancy counters.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
            r_ocnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_ocnt  <= w_ocnt_nxt;
        end
    end

    // Next state: dcnt counts consecutive agreeing samples, ocnt counts steady occupancy.
    // ocnt survives RELEASE->OCCUPIED so a chattering stuck loop still reaches FAULT.
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_ocnt_nxt  = r_ocnt;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_loop_s) begin
                    w_state_nxt = QUALIFY;
                    w_dcnt_nxt  = DCNT_ONE;
                end
            end
            QUALIFY: begin
                if (!w_loop_s) begin
                    w_state_nxt = IDLE;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt = OCCUPIED;
                    w_dcnt_nxt  = '0;
                    w_ocnt_nxt  = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_dcnt_nxt  = r_dcnt + DCNT_W'(1);
                end
            end
            OCCUPIED: begin
                if (!w_loop_s) begin
                    w_state_nxt = RELEASE;
                    w_dcnt_nxt  = DCNT_ONE;
                end else if (r_ocnt == OCNT_LAST) begin
                    w_state_nxt = FAULT;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_ocnt_nxt  = r_ocnt + OCNT_W'(1);
                end
            end
            RELEASE: begin
                if (w_loop_s) begin
                    w_state_nxt = OCCUPIED;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt  = r_dcnt + DCNT_W'(1);
                end
            end
            FAULT: begin
                // Leave only after a full debounce window of clear loop.
                if (w_loop_s) begin
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt  = r_dcnt + DCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_dcnt_nxt  = '0;
                w_ocnt_nxt  = '0;
            end
        endcase
    end

    // Demand latch: remembers a car that left before being served; GREEN clears and beats a same-edge set.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_demand_latch <= 1'b0;
        end else if (cntry == GREEN) begin
            r_demand_latch <= 1'b0;
        end else if (w_accept) begin
            r_demand_latch <= 1'b1;
        end
    end

`ifdef VEH_COUNT_EN
    logic [CNT_W-1:0] r_veh_count;

    // Saturating count of freshly qualified vehicles only.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_veh_count <= '0;
        end else if (w_accept && (r_veh_count != {CNT_W{1'b1}})) begin
            r_veh_count <= r_veh_count + CNT_W'(1);
        end
    end

    assign veh_count = r_veh_count;
`endif

    // Outputs decode registered state only.
    assign x           = state_has_vehicle(r_state) | r_demand_latch;
    assign stuck_fault = (r_state == FAULT);

endmodule

// File: tb/tb_vehicle_demand_detector.sv
// Randomised + directed bench for vehicle_demand_detector with a run-length reference model and scoreboard.
// Latency: expectations are queued per clock and checked 1 time unit after the edge.
// Backpressure: n/a.
module tb_vehicle_demand_detector;

    localparam int D = 4;
    localparam int S = 16;
`ifdef VEH_COUNT_EN
    localparam int CW = 3;
`else
    localparam int CW = 8;
`endif
    localparam logic [1:0] C_RED    = 2'd0;
    localparam logic [1:0] C_YELLOW = 2'd1;
    localparam logic [1:0] C_GREEN  = 2'd2;

    logic          clk = 1'b0;
    logic          clear;
    logic          loop_raw;
    logic [1:0]    cntry;
    logic          x;
    logic          stuck_fault;
`ifdef VEH_COUNT_EN
    logic [CW-1:0] veh_count;
`endif

    vehicle_demand_detector #(
        .DEBOUNCE_CYCLES (D),
        .STUCK_CYCLES    (S),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .loop_raw    (loop_raw),
        .cntry       (cntry),
`ifdef VEH_COUNT_EN
        .veh_count   (veh_count),
`endif
        .x           (x),
        .stuck_fault (stuck_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic x;
        logic stuck;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: loop seen two edges late; acceptance and release by run lengths of
    // equal samples; stuck time = 1-samples following a 1-sample while a car is present.
    logic m_meta, m_sync, m_prev;
    logic m_present, m_fault, m_latch;
    int   m_hi, m_lo, m_occ, m_cnt;

    task automatic model_reset();
        m_meta = 0; m_sync = 0; m_prev = 0;
        m_present = 0; m_fault = 0; m_latch = 0;
        m_hi = 0; m_lo = 0; m_occ = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic raw, input logic [1:0] cn);
        logic s;
        logic acc;
        s      = m_sync;
        m_sync = m_meta;
        m_meta = raw;
        acc    = 0;
        if (s) begin m_hi++; m_lo = 0; end
        else   begin m_lo++; m_hi = 0; end
        if (m_fault) begin
            if (m_lo >= D) m_fault = 0;
        end else if (m_present) begin
            if (!s) begin
                if (m_lo >= D) m_present = 0;
            end else if (m_prev) begin
                m_occ++;
                if (m_occ >= S) begin m_fault = 1; m_present = 0; end
            end
        end else if (m_hi >= D) begin
            acc = 1; m_present = 1; m_occ = 0;
        end
        m_prev = s;
        if (cn == C_GREEN) m_latch = 0;
        else if (acc)      m_latch = 1;
        if (acc && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d want %0d", nm, $time, got, want);
        end
    endtask

    // One clock of stimulus: drive at negedge, queue what the next edge must produce.
    task automatic cyc(input logic raw, input logic [1:0] cn);
        exp_t e;
        @(negedge clk);
        loop_raw = raw;
        cntry    = cn;
        model_step(raw, cn);
        e.x     = m_fault | m_present | m_latch;
        e.stuck = m_fault;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic cycn(input logic raw, input logic [1:0] cn, input int n);
        for (int i = 0; i < n; i++) cyc(raw, cn);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        clear    = 1'b0;
        loop_raw = 1'b0;
        #1;
        chk("reset_x", int'(x), 0);
        chk("reset_stuck", int'(stuck_fault), 0);
`ifdef VEH_COUNT_EN
        chk("reset_count", int'(veh_count), 0);
`endif
        model_reset();
        @(negedge clk);
        clear = 1'b1;
        model_step(1'b0, cntry);
        e.x     = m_fault | m_present | m_latch;
        e.stuck = m_fault;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: every output sample after an edge is compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("x", int'(x), int'(e.x));
                chk("stuck_fault", int'(stuck_fault), int'(e.stuck));
`ifdef VEH_COUNT_EN
                chk("veh_count", int'(veh_count), e.cnt);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

    // Stimulus: directed scenarios, then randomised loop run lengths and light codes.
    initial begin
        logic       r;
        logic [1:0] cn;
        int         len;
        int         pick;
        clear    = 1'b0;
        loop_raw = 1'b0;
        cntry    = C_RED;
        model_reset();
        #1;
        chk("init_x", int'(x), 0);
        chk("init_stuck", int'(stuck_fault), 0);
        do_reset();

        // Car arrives on RED, stays, leaves; latch holds demand until GREEN.
        cycn(1'b1, C_RED, 10);
        cycn(1'b0, C_RED, 8);
        cycn(1'b0, C_GREEN, 3);
        // Short glitch is rejected.
        cycn(1'b1, C_RED, 3);
        cycn(1'b0, C_RED, 8);
        // Car held 8 cycles then removed, latch, then GREEN.
        cycn(1'b1, C_RED, 8);
        cycn(1'b0, C_RED, 10);
        cycn(1'b0, C_GREEN, 2);
        // Stuck loop reaches FAULT, then recovers.
        do_reset();
        cycn(1'b1, C_RED, 30);
        cycn(1'b0, C_RED, 8);
        // Dropout shorter than debounce does not release; count unchanged.
        cycn(1'b1, C_YELLOW, 10);
        cycn(1'b0, C_YELLOW, 2);
        cycn(1'b1, C_YELLOW, 6);
        cycn(1'b0, C_GREEN, 10);
        // Chatter must not mask a stuck loop.
        for (int i = 0; i < 6; i++) begin
            cycn(1'b1, C_RED, 5);
            cycn(1'b0, C_RED, 2);
        end
        cycn(1'b0, C_RED, 8);
        // Arrival while GREEN and with illegal code 3.
        cycn(1'b1, C_GREEN, 8);
        cycn(1'b0, C_GREEN, 8);
        cycn(1'b1, 2'd3, 8);
        cycn(1'b0, 2'd3, 8);
        cycn(1'b0, C_GREEN, 2);
        // Reset mid-QUALIFY and mid-OCCUPIED.
        cycn(1'b1, C_RED, 4);
        do_reset();
        cycn(1'b1, C_RED, 9);
        do_reset();

        // Random run lengths around the debounce and stuck thresholds.
        r  = 1'b0;
        cn = C_RED;
        for (int blk = 0; blk < 450; blk++) begin
            r    = ~r;
            pick = $urandom_range(0, 99);
            if (pick < 65)      len = $urandom_range(1, D + 2);
            else if (pick < 90) len = $urandom_range(D + 3, 12);
            else                len = $urandom_range(S + 2, S + 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) cn = 2'($urandom_range(0, 3));
                cyc(r, cn);
            end
            if ($urandom_range(0, 60) == 0) do_reset();
        end
        cycn(1'b0, C_GREEN, 10);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
